trace_checker: RTL and testbench
================================

# trace_checker

Synthesizable commit-trace checker that sits directly downstream of `mycpu_top` and consumes its `debug_wb_*` writeback trace. Golden entries are pushed into an internal FIFO through a valid/ready port. Every register-file commit from the core pops one entry and is compared against it. The block reports pass count, first mismatch details, FIFO underflow and end-of-test. It is used in FPGA bring-up in place of the simulation-only trace compare.

## Interface
- `DEPTH`, 8: golden FIFO depth; power of two, ≥2.
- `END_PC`, 32'h1c00_0100: writeback PC that marks end of test.

- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `debug_wb_pc` in 32: PC of instruction in WB.
- `debug_wb_rf_we` in 4: byte write enables of commit.
- `debug_wb_rf_wnum` in 5: destination register.
- `debug_wb_rf_wdata` in 32: write data.
- `gold_valid` in 1: golden entry offered.
- `gold_ready` out 1: FIFO accepts the entry this cycle.
- `gold_pc` in 32: expected PC.
- `gold_wnum` in 5: expected destination.
- `gold_wdata` in 32: expected data, full word.
- `state` out 2: 00 RUN, 01 ERROR, 10 DONE.
- `err` out 1: sticky mismatch or underflow flag.
- `underflow` out 1: sticky; the error was a commit on an empty FIFO.
- `err_pc` out 32: `debug_wb_pc` of the faulting commit.
- `err_exp_wdata` out 32: masked golden data of the faulting commit.
- `err_got_wdata` out 32: masked core data of the faulting commit.
- `pass_cnt` out 32: number of matching commits.
- `gold_cnt` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Commit event: `|debug_wb_rf_we && debug_wb_rf_wnum != 0` while `state == RUN`. Writes to r0 and cycles with `we == 0` are ignored.
- Byte mask M: each byte is 8'hFF where the corresponding `we` bit is 1, else 8'h00. Match requires all three:
  - `debug_wb_pc == gold_pc`
  - `debug_wb_rf_wnum == gold_wnum`
  - `(debug_wb_rf_wdata & M) == (gold_wdata & M)`
- Push: `gold_valid && gold_ready`, where `gold_ready = (state == RUN) && (gold_cnt != DEPTH)`. `gold_ready` depends only on state and fullness, never on a same-cycle pop.
- Pop: every commit event with `gold_cnt != 0` pops the head entry, whether it matches or not.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. `gold_cnt` is `+1` on push only, `-1` on pop only, and unchanged on push and pop in the same cycle.

State machine (reset → RUN):
- **RUN**
  - Match: `pass_cnt` increments.
  - Mismatch: go to ERROR and latch `err_pc`, `err_exp_wdata`, `err_got_wdata`.
  - Commit with `gold_cnt == 0`: go to ERROR, set `underflow`, `err_exp_wdata = 0`, latch the core data.
  - `debug_wb_pc == END_PC` with no error in that cycle: go to DONE. A commit in that same cycle is still checked first; a mismatch takes priority and goes to ERROR.
- **ERROR**: terminal until reset. No pops, no pushes, counters frozen, latched fields hold.
- **DONE**: terminal until reset. Same freezing as ERROR; `err` stays 0.

Behaviour details:
- `pass_cnt` saturates at 32'hFFFF_FFFF.
- Empty FIFO with a simultaneous push and commit: no bypass. The commit is an underflow, and the push is still written.

## Timing
- Reset values: `state = 00`, `gold_ready = 1` the cycle after reset deasserts. `err`, `underflow`, `err_pc`, `err_exp_wdata`, `err_got_wdata`, `pass_cnt` and `gold_cnt` all reset to 0. FIFO contents are don't-care.
- While `reset` is high, `gold_ready = 0`.
- A pushed entry becomes comparable on the cycle after its push edge.
- Compare is combinational against the FIFO head; results register at the same edge. `err`, `state` and `pass_cnt` reflect commit N in cycle N+1.
- One commit per cycle is sustained, with one pop per cycle.
- Reset mid-test: on the next edge all state clears, including a sticky ERROR or DONE, and FIFO contents are discarded.

## Test plan
- Push 3 entries, then commit 3 matching (pc 1c000000/04/08, r1..r3): `pass_cnt = 3`, `gold_cnt = 0`, `err = 0`.
- Golden wdata 32'h1234_5678, core wdata 32'hAB34_5678 with `we = 4'b0111`: match. With `we = 4'b1111`: `err = 1`, `state = 01`, `err_got_wdata = 32'hAB34_5678`, `err_exp_wdata = 32'h1234_5678`.
- Commit with FIFO empty: `underflow = 1`, `state = 01`, `err_exp_wdata = 0`. A later push sees `gold_ready = 0`.
- Hold `gold_valid` high with no commits: exactly `DEPTH` entries accepted, `gold_ready` drops while `gold_cnt = DEPTH`. Then one commit per cycle with `gold_valid` still high: occupancy stays constant and entries survive pointer wrap-around correctly.
- `debug_wb_pc = END_PC` with a matching commit in the same cycle: `pass_cnt` increments and `state = 10`. With a mismatching commit instead: `state = 01`.
- Assert `reset` for one cycle while in ERROR: next cycle `state = 00`, `err = 0`, `pass_cnt = 0`, `gold_cnt = 0`.

Source files
------------

// File: rtl/trace_checker.sv
// Commit-trace checker: compares each register-file writeback from the core
// against golden entries queued in a small FIFO, and reports pass/fail status.
module trace_checker #(
    parameter int unsigned DEPTH  = 8,
    parameter logic [31:0] END_PC = 32'h1c00_0100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              debug_wb_pc,
    input  logic [3:0]               debug_wb_rf_we,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [31:0]              debug_wb_rf_wdata,
    input  logic                     gold_valid,
    output logic                     gold_ready,
    input  logic [31:0]              gold_pc,
    input  logic [4:0]               gold_wnum,
    input  logic [31:0]              gold_wdata,
    output logic [1:0]               state,
    output logic                     err,
    output logic                     underflow,
    output logic [31:0]              err_pc,
    output logic [31:0]              err_exp_wdata,
    output logic [31:0]              err_got_wdata,
    output logic [31:0]              pass_cnt,
    output logic [$clog2(DEPTH):0]   gold_cnt
);

    // state   | meaning
    // S_RUN   | accepting golden entries and checking commits
    // S_ERROR | mismatch or underflow seen; everything frozen until reset
    // S_DONE  | END_PC reached cleanly; everything frozen until reset

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_ERROR = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_fifo_pc    [DEPTH];
    logic [4:0]      r_fifo_wnum  [DEPTH];
    logic [31:0]     r_fifo_wdata [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;

    logic            r_err;
    logic            r_underflow;
    logic [31:0]     r_err_pc;
    logic [31:0]     r_err_exp;
    logic [31:0]     r_err_got;
    logic [31:0]     r_pass_cnt;

    logic [31:0]     w_mask;
    logic [31:0]     w_head_pc;
    logic [4:0]      w_head_wnum;
    logic [31:0]     w_head_wdata;
    logic            w_empty;
    logic            w_commit;
    logic            w_match;
    logic            w_push;
    logic            w_pop;
    logic            w_ready;
    logic            w_latch;
    logic            w_uf_set;
    logic            w_pass_inc;
    logic [31:0]     w_exp_masked;
    logic [31:0]     w_got_masked;

    assign w_mask = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                     {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};

    assign w_head_pc    = r_fifo_pc[r_rd_ptr];
    assign w_head_wnum  = r_fifo_wnum[r_rd_ptr];
    assign w_head_wdata = r_fifo_wdata[r_rd_ptr];

    assign w_empty  = (r_cnt == '0);
    assign w_commit = (r_state == S_RUN) && (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
    assign w_match  = (debug_wb_pc == w_head_pc) &&
                      (debug_wb_rf_wnum == w_head_wnum) &&
                      ((debug_wb_rf_wdata & w_mask) == (w_head_wdata & w_mask));

    // Ready never looks at a same-cycle pop, so a full FIFO refuses even while draining.
    assign w_ready = !reset && (r_state == S_RUN) && (r_cnt != C_FULL);
    assign w_push  = gold_valid && w_ready;
    assign w_pop   = w_commit && !w_empty;

    assign w_exp_masked = w_empty ? 32'd0 : (w_head_wdata & w_mask);
    assign w_got_masked = debug_wb_rf_wdata & w_mask;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_uf_set    = 1'b0;
        w_pass_inc  = 1'b0;
        if (r_state == S_RUN) begin
            if (w_commit && w_empty) begin
                w_state_nxt = S_ERROR;
                w_latch     = 1'b1;
                w_uf_set    = 1'b1;
            end else if (w_commit && !w_match) begin
                w_state_nxt = S_ERROR;
                w_latch     = 1'b1;
            end else begin
                w_pass_inc = w_commit;
                if (debug_wb_pc == END_PC) begin
                    w_state_nxt = S_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= gold_pc;
            r_fifo_wnum[r_wr_ptr]  <= gold_wnum;
            r_fifo_wdata[r_wr_ptr] <= gold_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_underflow <= 1'b0;
            r_err_pc    <= '0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_pass_cnt  <= '0;
        end else begin
            if (w_latch) begin
                r_err     <= 1'b1;
                r_err_pc  <= debug_wb_pc;
                r_err_exp <= w_exp_masked;
                r_err_got <= w_got_masked;
            end
            if (w_uf_set) begin
                r_underflow <= 1'b1;
            end
            if (w_pass_inc && (r_pass_cnt != 32'hFFFF_FFFF)) begin
                r_pass_cnt <= r_pass_cnt + 32'd1;
            end
        end
    end

    assign gold_ready    = w_ready;
    assign state         = r_state;
    assign err           = r_err;
    assign underflow     = r_underflow;
    assign err_pc        = r_err_pc;
    assign err_exp_wdata = r_err_exp;
    assign err_got_wdata = r_err_got;
    assign pass_cnt      = r_pass_cnt;
    assign gold_cnt      = r_cnt;

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trace_checker;

    localparam int unsigned DEPTH  = 8;
    localparam logic [31:0] END_PC = 32'h1c00_0100;
    localparam int unsigned AW     = $clog2(DEPTH);

    logic          clk;
    logic          reset;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_we;
    logic [4:0]    debug_wb_rf_wnum;
    logic [31:0]   debug_wb_rf_wdata;
    logic          gold_valid;
    logic          gold_ready;
    logic [31:0]   gold_pc;
    logic [4:0]    gold_wnum;
    logic [31:0]   gold_wdata;
    logic [1:0]    state;
    logic          err;
    logic          underflow;
    logic [31:0]   err_pc;
    logic [31:0]   err_exp_wdata;
    logic [31:0]   err_got_wdata;
    logic [31:0]   pass_cnt;
    logic [AW:0]   gold_cnt;

    trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .gold_valid        (gold_valid),
        .gold_ready        (gold_ready),
        .gold_pc           (gold_pc),
        .gold_wnum         (gold_wnum),
        .gold_wdata        (gold_wdata),
        .state             (state),
        .err               (err),
        .underflow         (underflow),
        .err_pc            (err_pc),
        .err_exp_wdata     (err_exp_wdata),
        .err_got_wdata     (err_got_wdata),
        .pass_cnt          (pass_cnt),
        .gold_cnt          (gold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } ent_t;

    ent_t        q[$];
    logic [1:0]  m_state;
    logic        m_err;
    logic        m_uf;
    logic [31:0] m_err_pc;
    logic [31:0] m_exp;
    logic [31:0] m_got;
    logic [31:0] m_pass;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        logic [31:0] m;
        m = 32'd0;
        for (int b = 0; b < 4; b++) if (we[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_state  = 2'b00;
        m_err    = 1'b0;
        m_uf     = 1'b0;
        m_err_pc = 32'd0;
        m_exp    = 32'd0;
        m_got    = 32'd0;
        m_pass   = 32'd0;
    endtask

    // Applies the checker's rules to the inputs present at the rising edge.
    task automatic model_update();
        ent_t        h;
        logic [31:0] m;
        logic        commit;
        logic        push;
        logic        bad;
        if (reset) begin
            model_reset();
        end else if (m_state == 2'b00) begin
            m      = byte_mask(debug_wb_rf_we);
            commit = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
            push   = gold_valid && (q.size() != DEPTH);
            bad    = 1'b0;
            if (commit) begin
                if (q.size() == 0) begin
                    bad   = 1'b1;
                    m_uf  = 1'b1;
                    m_exp = 32'd0;
                end else begin
                    h = q.pop_front();
                    if (h.pc != debug_wb_pc || h.wnum != debug_wb_rf_wnum ||
                        (h.wdata & m) != (debug_wb_rf_wdata & m)) begin
                        bad   = 1'b1;
                        m_exp = h.wdata & m;
                    end else if (m_pass != 32'hFFFF_FFFF) begin
                        m_pass = m_pass + 32'd1;
                    end
                end
                if (bad) begin
                    m_err    = 1'b1;
                    m_err_pc = debug_wb_pc;
                    m_got    = debug_wb_rf_wdata & m;
                    m_state  = 2'b01;
                end
            end
            if (!bad && debug_wb_pc == END_PC) m_state = 2'b10;
            if (push) q.push_back('{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata});
        end
    endtask

    task automatic compare_all();
        logic exp_ready;
        exp_ready = !reset && (m_state == 2'b00) && (q.size() != DEPTH);
        chk("gold_ready", gold_ready, exp_ready);
        chk("state", state, m_state);
        chk("err", err, m_err);
        chk("underflow", underflow, m_uf);
        chk("err_pc", err_pc, m_err_pc);
        chk("err_exp_wdata", err_exp_wdata, m_exp);
        chk("err_got_wdata", err_got_wdata, m_got);
        chk("pass_cnt", pass_cnt, m_pass);
        chk("gold_cnt", gold_cnt, 64'(q.size()));
    endtask

    task automatic idle_inputs();
        debug_wb_pc       = 32'd0;
        debug_wb_rf_we    = 4'd0;
        debug_wb_rf_wnum  = 5'd0;
        debug_wb_rf_wdata = 32'd0;
        gold_valid        = 1'b0;
        gold_pc           = 32'd0;
        gold_wnum         = 5'd0;
        gold_wdata        = 32'd0;
    endtask

    // One cycle: check outputs at the falling edge, advance model at the rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        gold_valid = 1'b1; gold_pc = pc; gold_wnum = wn; gold_wdata = wd;
        step();
    endtask

    task automatic commit(input logic [31:0] pc, input logic [3:0] we,
                          input logic [4:0] wn, input logic [31:0] wd);
        debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
        step();
    endtask

    initial begin
        int stuck;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_state", state, 2'b00);
        chk("rst_ready", gold_ready, 1'b1);
        chk("rst_cnt", gold_cnt, 0);

        // three matching commits
        for (int i = 0; i < 3; i++) push(32'h1c00_0000 + 32'(4 * i), 5'(i + 1), 32'hA000_0000 + 32'(i));
        chk("plan_cnt3", gold_cnt, 3);
        for (int i = 0; i < 3; i++) commit(32'h1c00_0000 + 32'(4 * i), 4'hF, 5'(i + 1), 32'hA000_0000 + 32'(i));
        chk("plan_pass3", pass_cnt, 3);
        chk("plan_cnt0", gold_cnt, 0);
        chk("plan_err0", err, 1'b0);

        // byte-mask match, then full-word mismatch
        push(32'h1c00_0010, 5'd5, 32'h1234_5678);
        commit(32'h1c00_0010, 4'b0111, 5'd5, 32'hAB34_5678);
        chk("mask_pass4", pass_cnt, 4);
        chk("mask_err0", err, 1'b0);
        push(32'h1c00_0014, 5'd5, 32'h1234_5678);
        commit(32'h1c00_0014, 4'b1111, 5'd5, 32'hAB34_5678);
        chk("mm_err", err, 1'b1);
        chk("mm_state", state, 2'b01);
        chk("mm_got", err_got_wdata, 32'hAB34_5678);
        chk("mm_exp", err_exp_wdata, 32'h1234_5678);
        chk("mm_pc", err_pc, 32'h1c00_0014);

        // underflow
        do_reset();
        commit(32'h1c00_0020, 4'hF, 5'd3, 32'h0000_0055);
        chk("uf_flag", underflow, 1'b1);
        chk("uf_state", state, 2'b01);
        chk("uf_exp", err_exp_wdata, 32'd0);
        chk("uf_got", err_got_wdata, 32'h0000_0055);
        chk("uf_ready", gold_ready, 1'b0);
        push(32'h1c00_0024, 5'd4, 32'h1);
        chk("uf_cnt", gold_cnt, 0);

        // fill to DEPTH, then sustained commit+push across pointer wrap
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) push(32'h1c00_0000 + 32'(4 * i), 5'(i % 31 + 1), $urandom);
        chk("fill_cnt", gold_cnt, DEPTH);
        chk("fill_ready", gold_ready, 1'b0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            gold_valid = 1'b1;
            gold_pc    = 32'h1c00_0040 + 32'(4 * i);
            gold_wnum  = 5'(i % 31 + 1);
            gold_wdata = $urandom;
            debug_wb_pc       = q[0].pc;
            debug_wb_rf_we    = 4'hF;
            debug_wb_rf_wnum  = q[0].wnum;
            debug_wb_rf_wdata = q[0].wdata;
            step();
        end
        chk("wrap_pass", pass_cnt, 2 * DEPTH);
        chk("wrap_cnt", gold_cnt, DEPTH - 1);
        chk("wrap_err", err, 1'b0);

        // END_PC with matching and mismatching commit
        do_reset();
        push(END_PC, 5'd7, 32'h0000_CAFE);
        commit(END_PC, 4'hF, 5'd7, 32'h0000_CAFE);
        chk("end_pass", pass_cnt, 1);
        chk("end_state", state, 2'b10);
        chk("end_err", err, 1'b0);
        do_reset();
        push(END_PC, 5'd7, 32'h0000_CAFE);
        commit(END_PC, 4'hF, 5'd7, 32'h0000_BEEF);
        chk("endmm_state", state, 2'b01);

        // one-cycle reset out of ERROR
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rerr_state", state, 2'b00);
        chk("rerr_err", err, 1'b0);
        chk("rerr_pass", pass_cnt, 0);
        chk("rerr_cnt", gold_cnt, 0);
        step();

        // randomized traffic
        for (int run = 0; run < 12; run++) begin
            do_reset();
            stuck = 0;
            for (int c = 0; c < 250 && stuck < 3; c++) begin
                gold_valid = ($urandom_range(0, 2) != 0);
                gold_pc    = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 80));
                gold_wnum  = 5'($urandom_range(0, 31));
                gold_wdata = $urandom;
                debug_wb_pc = ($urandom_range(0, 60) == 0) ? END_PC : 32'h1c00_0000 + 32'(4 * $urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) begin
                    debug_wb_rf_we = 4'($urandom_range(0, 15));
                    if (q.size() > 0 && $urandom_range(0, 39) != 0) begin
                        debug_wb_pc       = q[0].pc;
                        debug_wb_rf_wnum  = q[0].wnum;
                        debug_wb_rf_wdata = q[0].wdata ^ (($urandom_range(0, 29) == 0) ? 32'h0100_0001 : 32'd0);
                    end else if (q.size() > 0 || $urandom_range(0, 19) == 0) begin
                        debug_wb_rf_wnum  = 5'($urandom_range(0, 31));
                        debug_wb_rf_wdata = $urandom;
                    end else begin
                        debug_wb_rf_we = 4'd0;
                    end
                end
                if ($urandom_range(0, 149) == 0) reset = 1'b1;
                step();
                reset = 1'b0;
                if (m_state != 2'b00) stuck++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
